ahb_rr_prior_arbiter: RTL



---
 rtl/ahb_rr_prior_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/ahb_rr_prior_arbiter.sv
// Registered AHB arbiter: priority levels with round-robin among equal-level requesters, grant held for a whole burst.
// Optional wait-counter aging that promotes starved masters is enabled by defining AHB_ARB_AGING_EN.
module ahb_rr_prior_arbiter #(
    parameter int REQ_NUM     = 8,
    parameter int PRIOR_BIT   = 2,
    parameter int PRIOR_LEVEL = 4,
    parameter int IDX_W       = $clog2(REQ_NUM),
    parameter int AGE_LIMIT   = 16
) (
    input  logic                               hclk,
    input  logic                               hreset,
    input  logic [REQ_NUM-1:0]                 hreq,
    input  logic [REQ_NUM-1:0][PRIOR_BIT-1:0]  hprior,
    input  logic [REQ_NUM-1:0]                 hlast,
    input  logic                               hready,
    output logic [REQ_NUM-1:0]                 grant,
    output logic [IDX_W-1:0]                   grant_idx,
    output logic                               grant_valid,
    output logic [IDX_W-1:0]                   rr_ptr
);

    typedef enum logic {IDLE, OWN} state_e;

    state_e                             state_q, state_d;
    logic [REQ_NUM-1:0]                 grant_q, grant_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic                               valid_q, valid_d;
    logic [IDX_W-1:0]                   rr_q, rr_d;

    logic [REQ_NUM-1:0][PRIOR_BIT-1:0]  eff_prio;
    logic [REQ_NUM-1:0]                 elig, lvl_mask;
    logic [PRIOR_BIT-1:0]               max_lvl;
    logic [IDX_W-1:0]                   win_idx;
    logic                               found;
    logic                               release_ev;

`ifdef AHB_ARB_AGING_EN
    logic [REQ_NUM-1:0][7:0] age_q, age_d;

    always_comb begin
        age_d = age_q;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (!hreq[i] || grant_q[i])
                age_d[i] = 8'd0;
            else if (age_q[i] != 8'hFF)
                age_d[i] = age_q[i] + 8'd1;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) age_q <= '0;
        else        age_q <= age_d;
    end

    // Aged masters compete at the top level; ties among them fall to round-robin.
    always_comb begin
        eff_prio = hprior;
        for (int i = 0; i < REQ_NUM; i++)
            if (int'(age_q[i]) >= AGE_LIMIT)
                eff_prio[i] = PRIOR_BIT'(PRIOR_LEVEL - 1);
    end
`else
    logic unused_age;
    assign unused_age = (AGE_LIMIT != 0);
    assign eff_prio   = hprior;
`endif

    assign release_ev = (hreq[idx_q] & hlast[idx_q] & hready) | ~hreq[idx_q];

    // The outgoing owner is left out so a burst can't be followed by its own re-grant.
    always_comb begin
        elig = '0;
        if (state_q == IDLE)  elig = hreq;
        else if (release_ev)  elig = hreq & ~grant_q;
    end

    always_comb begin
        max_lvl = '0;
        for (int i = 0; i < REQ_NUM; i++)
            if (elig[i] && eff_prio[i] > max_lvl) max_lvl = eff_prio[i];
        for (int i = 0; i < REQ_NUM; i++)
            lvl_mask[i] = elig[i] && (eff_prio[i] == max_lvl);
        win_idx = '0;
        found   = 1'b0;
        for (int k = 1; k <= REQ_NUM; k++) begin
            int cand;
            cand = (int'(rr_q) + k) % REQ_NUM;
            if (!found && lvl_mask[IDX_W'(cand)]) begin
                win_idx = IDX_W'(cand);
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        rr_d    = rr_q;
        if (state_q == IDLE || release_ev) begin
            if (found) begin
                state_d = OWN;
                grant_d = REQ_NUM'(1) << win_idx;
                idx_d   = win_idx;
                valid_d = 1'b1;
                rr_d    = win_idx;
            end else begin
                state_d = IDLE;
                grant_d = '0;
                idx_d   = '0;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            rr_q    <= IDX_W'(REQ_NUM - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            rr_q    <= rr_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign grant_valid = valid_q;
    assign rr_ptr      = rr_q;

endmodule
